// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES round sequencer; optional abort input under AES_ROUND_CTRL_ABORT_EN
module aes_round_ctrl #(
    parameter int   NUM_ROUNDS = 10,
    parameter logic INVERSE    = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY0  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state;
    logic [127:0] st_q;
    logic [3:0]   rnd;
    logic         abort_hit;

    // Decryption walks the key schedule backwards from the last round key.
    function automatic logic [3:0] key_index(input logic [3:0] r);
        return INVERSE ? (LAST - r) : r;
    endfunction

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign dp_state = st_q;
    assign dp_key   = rk_data;
    assign out_data = st_q;

    // Block sequencing: state, round counter, working state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            st_q      <= '0;
            rnd       <= '0;
            in_ready  <= 1'b1;
            rk_req    <= 1'b0;
            rk_idx    <= '0;
            dp_final  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort_hit) begin
            // The working state is deliberately left as-is; only control is unwound.
            state     <= IDLE;
            rnd       <= '0;
            in_ready  <= 1'b1;
            rk_req    <= 1'b0;
            rk_idx    <= '0;
            dp_final  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_q     <= in_data;
                        state    <= KEY0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        rk_req   <= 1'b1;
                        rk_idx   <= key_index(4'd0);
                    end
                end
                KEY0: begin
                    if (rk_valid) begin
                        st_q     <= st_q ^ rk_data;
                        rnd      <= 4'd1;
                        state    <= ROUND;
                        rk_idx   <= key_index(4'd1);
                        dp_final <= (LAST == 4'd1);
                    end
                end
                ROUND: begin
                    if (rk_valid) begin
                        st_q <= dp_result;
                        if (rnd == LAST) begin
                            state     <= DONE;
                            rk_req    <= 1'b0;
                            rk_idx    <= '0;
                            dp_final  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            rnd      <= rnd + 4'd1;
                            rk_idx   <= key_index(rnd + 4'd1);
                            dp_final <= ((rnd + 4'd1) == LAST);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        rnd       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative round controller for the AES core. It accepts one 128-bit block, sequences the initial AddRoundKey and NUM_ROUNDS cipher rounds through an external combinational round datapath (SubBytes, then ShiftRows, then MixColumns, then AddRoundKey), and fetches one round key per round over a request/valid handshake from the key schedule. It holds the result until the downstream stage accepts it. It sits between the block input interface and the shared round datapath and key-expansion unit.

## Interface
Parameters:
- NUM_ROUNDS, default 10: cipher rounds; legal values are 10, 12 and 14 (AES-128/192/256).
- INVERSE, default 1'b0: 0 = encryption key order; 1 = decryption (equivalent inverse cipher) key order.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  input block valid.
- in_ready  output  1  controller can accept a block.
- in_data  input  128  plaintext/ciphertext, byte i at [8i+:8].
- rk_req  output  1  round-key request.
- rk_idx  output  4  requested round-key index.
- rk_valid  input  1  rk_data valid for current rk_idx.
- rk_data  input  128  round key.
- dp_state  output  128  state presented to round datapath.
- dp_key  output  128  key presented to datapath (equals rk_data).
- dp_final  output  1  final round; datapath skips (Inv)MixColumns.
- dp_result  input  128  combinational round output.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  128  result block.
- busy  output  1  high in any state other than IDLE.

## Operation
FSM states and transitions:
- IDLE: in_ready=1. On in_valid&&in_ready: st_q<=in_data, go to KEY0.
- KEY0: rk_req=1, rk_idx = 0 (INVERSE=0) or NUM_ROUNDS (INVERSE=1). On rk_valid: st_q<=st_q^rk_data, rnd<=1, go to ROUND.
- ROUND: rk_req=1, rk_idx = rnd (INVERSE=0) or NUM_ROUNDS-rnd (INVERSE=1), dp_state=st_q, dp_final=(rnd==NUM_ROUNDS).
  - On rk_valid: st_q<=dp_result.
  - If rnd==NUM_ROUNDS, go to DONE; otherwise rnd<=rnd+1.
- DONE: out_valid=1, out_data=st_q. On out_ready, go to IDLE.

Outputs and rules:
- rk_req is low, and rk_idx=0, outside KEY0 and ROUND.
- dp_final=0 outside ROUND.
- rk_valid without rk_req is ignored.
- rk_valid low stalls the current state indefinitely. rk_req, rk_idx and dp_state stay stable while stalled.
- in_valid outside IDLE is ignored; in_ready=0.
- rnd is 4 bits and never exceeds NUM_ROUNDS; there is no wrap.

Reset (rst_n low at an edge) forces:
- FSM to IDLE.
- st_q=0 and rnd=0.
- out_valid=0, rk_req=0, busy=0, in_ready=1 from the first post-reset cycle.

Reset mid-round or mid-DONE discards the block. No out_valid is produced for it.

## Timing
- Accept at edge T. KEY0 during cycle T+1. ROUND rnd=1..NUM_ROUNDS during cycles T+2..T+NUM_ROUNDS+1. out_valid first high in cycle T+NUM_ROUNDS+2 (T+12 for 10 rounds), assuming rk_valid is held high.
- Each rk_valid-low cycle adds one cycle of latency.
- in_ready returns the cycle after the out_valid&&out_ready edge. Minimum block period is NUM_ROUNDS+3 cycles.
- out_data and out_valid are registered and held stable until the handshake.

## Configuration
- AES_ROUND_CTRL_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort high at an edge in any non-IDLE state forces IDLE, rnd=0, out_valid=0 next cycle.
  - st_q is not cleared.
  - abort has lower priority than rst_n and is ignored in IDLE.
- Macro undefined: the port does not exist, and the FSM leaves a block only via DONE handshake or reset.

## Test plan
- FIPS-197 C.1, INVERSE=0, reference datapath and key-schedule models, rk_valid=1, key 000102...0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a at T+12; rk_idx sequence 0,1,...,10; dp_final high only at rk_idx=10.
- INVERSE=1, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff; rk_idx sequence 10,9,...,0.
- rk_valid low for 3 cycles at rnd=5 -> rk_idx holds 5 and dp_state is unchanged; out_valid arrives at T+15 with the same ciphertext.
- out_ready low for 4 cycles in DONE -> out_valid and out_data stable, in_ready=0, a second in_valid is ignored; accept occurs the cycle after the handshake.
- rst_n low for 1 cycle at rnd=7 -> next cycle IDLE, busy=0, rk_req=0; no out_valid for the dropped block; the following block processes correctly.
- With AES_ROUND_CTRL_ABORT_EN: abort at rnd=3 -> IDLE next cycle, out_valid never asserts, in_ready=1.
